// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the single SoC bus master port.
// One outstanding transfer at a time; a watchdog turns a silent slave into an error response.
module bus_arbiter #(
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        clk_i,
  input  logic        n_rst_i,

  input  logic        m0_req_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_data_i,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_data_o,
  output logic        m0_err_o,

  input  logic        m1_req_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_data_i,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_data_o,
  output logic        m1_err_o,

  output logic        s_req_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_addr_o,
  output logic        s_we_o,
  output logic [31:0] s_data_o,
  input  logic        s_rvalid_i,
  input  logic [31:0] s_data_i,

  output logic        grant_o
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             rr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             winner;
  logic             finish;
  logic [31:0]      resp_data;

  // A lone requester always wins; a tie goes to the master rr_ptr points at.
  assign winner    = (m0_req_i && m1_req_i) ? rr_ptr : m1_req_i;
  assign finish    = s_rvalid_i || (cnt == CNT_LAST);
  assign resp_data = s_rvalid_i ? s_data_i : ERR_DATA;
  assign s_req_o   = (state == BUSY);

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state       <= IDLE;
      rr_ptr      <= 1'b0;
      cnt         <= '0;
      grant_o     <= 1'b0;
      s_sel_o     <= '0;
      s_addr_o    <= '0;
      s_we_o      <= 1'b0;
      s_data_o    <= '0;
      m0_rvalid_o <= 1'b0;
      m0_err_o    <= 1'b0;
      m0_data_o   <= '0;
      m1_rvalid_o <= 1'b0;
      m1_err_o    <= 1'b0;
      m1_data_o   <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so these defaults are simply
      // overridden by the later assignment in the RESP-entry branch below.
      m0_rvalid_o <= 1'b0;
      m0_err_o    <= 1'b0;
      m1_rvalid_o <= 1'b0;
      m1_err_o    <= 1'b0;

      unique case (state)
        IDLE: begin
          if (m0_req_i || m1_req_i) begin
            s_sel_o  <= winner ? m1_sel_i  : m0_sel_i;
            s_addr_o <= winner ? m1_addr_i : m0_addr_i;
            s_we_o   <= winner ? m1_we_i   : m0_we_i;
            s_data_o <= winner ? m1_data_i : m0_data_i;
            grant_o  <= winner;
            rr_ptr   <= ~winner;
            cnt      <= '0;
            state    <= BUSY;
          end
        end

        BUSY: begin
          cnt <= cnt + 1'b1;
          // Slave response wins over the watchdog when both land on the same cycle.
          if (finish) begin
            state <= RESP;
            if (grant_o) begin
              m1_rvalid_o <= 1'b1;
              m1_data_o   <= resp_data;
              m1_err_o    <= !s_rvalid_i;
            end else begin
              m0_rvalid_o <= 1'b1;
              m0_data_o   <= resp_data;
              m0_err_o    <= !s_rvalid_i;
            end
          end
        end

        RESP: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, hand-written corner
// sequences, then randomized transfers against a transaction-level reference model.
module tb_bus_arbiter;

  localparam int          T   = 16;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk_i = 1'b0;
  logic        n_rst_i;
  logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic [31:0] m0_addr_i, m0_data_i, m1_addr_i, m1_data_i;
  logic        m0_rvalid_o, m0_err_o, m1_rvalid_o, m1_err_o;
  logic [31:0] m0_data_o, m1_data_o;
  logic        s_req_o, s_we_o, s_rvalid_i, grant_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_addr_o, s_data_o, s_data_i;

  int checks = 0;
  int errors = 0;

  bus_arbiter #(.TIMEOUT_CYCLES(T), .ERR_DATA(ERR)) dut (
    .clk_i(clk_i), .n_rst_i(n_rst_i),
    .m0_req_i(m0_req_i), .m0_sel_i(m0_sel_i), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
    .m0_data_i(m0_data_i), .m0_rvalid_o(m0_rvalid_o), .m0_data_o(m0_data_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_sel_i(m1_sel_i), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
    .m1_data_i(m1_data_i), .m1_rvalid_o(m1_rvalid_o), .m1_data_o(m1_data_o), .m1_err_o(m1_err_o),
    .s_req_o(s_req_o), .s_sel_o(s_sel_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
    .s_data_o(s_data_o), .s_rvalid_i(s_rvalid_i), .s_data_i(s_data_i), .grant_o(grant_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        r0, r1;
    logic [31:0] a0, a1, d0, d1;
    logic        we;
    int          lat;        // busy cycles before slave answers; >= T means never
    logic [31:0] rdata;
    logic        exp_g;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_cyc;    // cycles s_req_o stays high
  } vec_t;

  vec_t tbl[12];

  // Expected completion follows directly from the latency/timeout rule.
  function automatic vec_t mk(input logic r0, input logic r1, input logic [31:0] a0,
                              input logic [31:0] a1, input logic [31:0] d0, input logic [31:0] d1,
                              input logic we, input int lat, input logic [31:0] rdata, input logic g);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.we = we; v.lat = lat; v.rdata = rdata; v.exp_g = g;
    v.exp_err   = (lat >= T);
    v.exp_rdata = (lat >= T) ? ERR : rdata;
    v.exp_cyc   = (lat >= T) ? T : lat + 1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "/s_addr"}, s_addr_o, 32'h0);
    check({tag, "/s_data"}, s_data_o, 32'h0);
    check({tag, "/m0_data"}, m0_data_o, 32'h0);
    check({tag, "/m1_data"}, m1_data_o, 32'h0);
    check({tag, "/flags"}, {s_req_o, s_we_o, s_sel_o, grant_o,
                           m0_rvalid_o, m0_err_o, m1_rvalid_o, m1_err_o}, 32'h0);
  endtask

  task automatic apply_reset();
    n_rst_i = 1'b0;
    m0_req_i = 0; m1_req_i = 0; m0_we_i = 0; m1_we_i = 0;
    m0_sel_i = 0; m1_sel_i = 0; m0_addr_i = 0; m1_addr_i = 0;
    m0_data_i = 0; m1_data_i = 0; s_rvalid_i = 0; s_data_i = 0;
    tick();
    tick();
    check_zero("reset");
    n_rst_i = 1'b1;
    tick();
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    logic [31:0] exp_addr, exp_wd;
    logic [4:0]  exp_we_sel;
    m0_req_i = v.r0;  m1_req_i = v.r1;
    m0_addr_i = v.a0; m1_addr_i = v.a1;
    m0_data_i = v.d0; m1_data_i = v.d1;
    m0_sel_i = v.a0[3:0]; m1_sel_i = v.a1[7:4];
    m0_we_i = v.we;   m1_we_i = ~v.we;
    s_rvalid_i = 1'b0;
    exp_addr   = v.exp_g ? v.a1 : v.a0;
    exp_wd     = v.exp_g ? v.d1 : v.d0;
    exp_we_sel = v.exp_g ? {~v.we, v.a1[7:4]} : {v.we, v.a0[3:0]};

    tick();
    check({tag, "/s_req"}, 32'(s_req_o), 32'h1);
    check({tag, "/grant"}, 32'(grant_o), 32'(v.exp_g));
    check({tag, "/s_addr"}, s_addr_o, exp_addr);
    check({tag, "/s_wdata"}, s_data_o, exp_wd);
    check({tag, "/we_sel"}, 32'({s_we_o, s_sel_o}), 32'(exp_we_sel));

    n = 0;
    while (s_req_o && n < 4 * T) begin
      if (n == v.lat) begin
        s_rvalid_i = 1'b1;
        s_data_i   = v.rdata;
      end
      tick();
      s_rvalid_i = 1'b0;
      s_data_i   = $urandom();
      n++;
    end
    check({tag, "/busy_cycles"}, 32'(n), 32'(v.exp_cyc));
    check({tag, "/rvalid"}, 32'({m1_rvalid_o, m0_rvalid_o}), v.exp_g ? 32'h2 : 32'h1);
    check({tag, "/rdata"}, v.exp_g ? m1_data_o : m0_data_o, v.exp_rdata);
    check({tag, "/err"}, 32'({m1_err_o, m0_err_o}),
          v.exp_err ? (v.exp_g ? 32'h2 : 32'h1) : 32'h0);

    if (v.exp_g) m1_req_i = 1'b0;
    else         m0_req_i = 1'b0;
    tick();
    check({tag, "/rvalid_drop"}, 32'({m1_rvalid_o, m0_rvalid_o}), 32'h0);
  endtask

  // Transaction-level reference state for the randomized phase.
  logic        pref, h0, h1;
  logic [31:0] fa0, fa1, fd0, fd1;
  logic        fwe;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 6; i++)
      tbl[i] = mk(1, 1, 32'h100 + 32'(16 * i), 32'h200 + 32'(16 * i),
                  32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i), 1, 1, 32'h0, 1'(i % 2));
    tbl[6]  = mk(1, 0, 32'h0000_1000, 32'h0, 32'h0, 32'h0, 0, 0, 32'h1234_5678, 0);
    tbl[7]  = mk(0, 1, 32'h0, 32'h0000_2000, 32'h0, 32'h0, 0, 99, 32'h1111_1111, 1);
    tbl[8]  = mk(1, 0, 32'h0000_3000, 32'h0, 32'h0, 32'h0, 0, T - 1, 32'hCAFE_F00D, 0);
    tbl[9]  = mk(0, 1, 32'h0, 32'h0000_2040, 32'h0, 32'h9, 1, 3, 32'hA5A5_0001, 1);
    tbl[10] = mk(1, 1, 32'h0000_3100, 32'h0000_2080, 32'h1, 32'h2, 1, 0, 32'h5, 0);
    tbl[11] = mk(0, 1, 32'h0, 32'h0000_2080, 32'h0, 32'h2, 1, 2, 32'h6, 1);

    apply_reset();

    for (int i = 0; i < 12; i++)
      run_vec(tbl[i], $sformatf("tbl%0d", i));

    // Stray slave responses outside BUSY, and master field changes while BUSY.
    s_rvalid_i = 1'b1; s_data_i = 32'h0BAD_0BAD;
    tick();
    check("stray_idle/rvalid", 32'({m1_rvalid_o, m0_rvalid_o, s_req_o}), 32'h0);
    s_rvalid_i = 1'b0;
    m0_req_i = 1'b1; m0_addr_i = 32'h0000_4000; m0_we_i = 1'b0;
    tick();
    check("addr_hold/first", s_addr_o, 32'h0000_4000);
    m0_addr_i = 32'h0000_4444;
    tick();
    check("addr_hold/busy", s_addr_o, 32'h0000_4000);
    check("addr_hold/s_req", 32'(s_req_o), 32'h1);
    s_rvalid_i = 1'b1; s_data_i = 32'h0000_0055;
    tick();
    check("addr_hold/rvalid", 32'({m1_rvalid_o, m0_rvalid_o}), 32'h1);
    check("addr_hold/rdata", m0_data_o, 32'h0000_0055);
    m0_req_i = 1'b0; s_data_i = 32'h0000_0066;
    tick();
    check("stray_resp/rvalid", 32'({m1_rvalid_o, m0_rvalid_o, s_req_o}), 32'h0);
    tick();
    check("stray_idle2/rvalid", 32'({m1_rvalid_o, m0_rvalid_o, s_req_o}), 32'h0);
    s_rvalid_i = 1'b0;

    // Reset in the middle of an m0 transfer (which points rr at m1).
    m0_req_i = 1'b1; m0_addr_i = 32'h0000_5000; m0_data_i = 32'h77;
    tick();
    check("abort/s_req", 32'({s_req_o, grant_o}), 32'h2);
    #2 n_rst_i = 1'b0;
    #1 check_zero("abort_async");
    m0_req_i = 1'b0;
    tick();
    tick();
    check("abort/in_reset", 32'({m1_rvalid_o, m0_rvalid_o, s_req_o}), 32'h0);
    #2 n_rst_i = 1'b1;
    tick();
    check("abort/after", 32'({m1_rvalid_o, m0_rvalid_o, s_req_o}), 32'h0);
    run_vec(mk(1, 1, 32'h0000_6000, 32'h0000_7000, 32'h61, 32'h71, 1, 1, 32'h99, 0), "abort_tie");

    // Randomized transfers against the reference model.
    apply_reset();
    pref = 1'b0; h0 = 1'b0; h1 = 1'b0;
    fa0 = 0; fa1 = 0; fd0 = 0; fd1 = 0; fwe = 0;
    for (int it = 0; it < 60; it++) begin
      vec_t v;
      int   lat;
      logic w;
      if (!h0 && ($urandom() % 2 == 0)) begin h0 = 1'b1; fa0 = $urandom(); fd0 = $urandom(); end
      if (!h1 && ($urandom() % 2 == 0)) begin h1 = 1'b1; fa1 = $urandom(); fd1 = $urandom(); end
      if (!h0 && !h1) begin
        m0_req_i = 1'b0; m1_req_i = 1'b0;
        tick();
        check("rand_idle/s_req", 32'({s_req_o, m1_rvalid_o, m0_rvalid_o}), 32'h0);
        continue;
      end
      w    = (h0 && h1) ? pref : h1;
      pref = ~w;
      fwe  = 1'($urandom());
      lat  = ($urandom() % 4 == 0) ? int'($urandom_range(0, T + 3)) : int'($urandom_range(0, 3));
      v    = mk(h0, h1, fa0, fa1, fd0, fd1, fwe, lat, $urandom(), w);
      run_vec(v, $sformatf("rand%0d", it));
      if (w) h1 = 1'b0;
      else   h0 = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
